// File: rtl/arb_pkg.sv
// ---------------------------------------------------------------------------
// arb_pkg
//   Shared constants and helpers for the round-robin queue arbiter.
//   STAT_CNT_W : width of each per-queue grant counter.
//   qid_width  : index width for n queues, never less than 1 bit.
//   rst_owner  : owner value after reset. Making the last queue the owner
//                gives queue 0 first priority.
// ---------------------------------------------------------------------------
package arb_pkg;

  localparam int STAT_CNT_W = 32;

  function automatic int qid_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int rst_owner(input int n);
    return n - 1;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// ---------------------------------------------------------------------------
// rr_priority_pick
//   Purely combinational rotating priority search. The block scans req
//   starting at start_idx and wraps modulo N. The first set bit it finds
//   is the grant.
//   Ports:
//     req         : request vector, one bit per queue
//     start_idx   : first index to examine (must be < N)
//     grant_valid : at least one request bit is set
//     grant_idx   : index of the winning request (0 when none)
// ---------------------------------------------------------------------------
module rr_priority_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start_idx,
  output logic          grant_valid,
  output logic [IW-1:0] grant_idx
);

  always_comb begin
    int j;
    // NOTE: every output gets a default before the search loop. This keeps
    // the block free of inferred latches when no request is set.
    grant_valid = 1'b0;
    grant_idx   = '0;
    j           = 0;
    for (int i = 0; i < N; i++) begin
      j = int'(start_idx) + i;
      if (j >= N) j = j - N;
      if (!grant_valid && req[j]) begin
        grant_valid = 1'b1;
        grant_idx   = IW'(j);
      end
    end
  end

endmodule

// File: rtl/rr_queue_arbiter.sv
// ---------------------------------------------------------------------------
// rr_queue_arbiter
//   Drains a bank of NUM_QUEUES registered-output FIFOs into one egress
//   register. On each cycle the block grants one non-empty queue by round
//   robin. The current owner may keep the grant for up to MAX_BURST
//   consecutive words. When the sink is always ready, the block sustains
//   one word per cycle.
//
//   Ports:
//     clk_i            : clock, rising edge
//     rst_n_i          : asynchronous active-low reset
//     q_data_i         : head word of each queue, slice k = [k*WIDTH +: WIDTH]
//     q_valid_i        : head word valid, one bit per queue
//     q_pop_o          : combinational pop strobe, one-hot or zero
//     data_o           : registered egress word
//     qid_o            : source queue of data_o
//     valid_o          : egress word valid
//     ready_i          : egress sink accepts data_o this cycle
//   Optional (macro ARB_GRANT_STATS_EN):
//     stat_clr_i       : synchronous clear of all grant counters
//     stat_grant_cnt_o : saturating pop count per queue, 32 bits per slice
// ---------------------------------------------------------------------------
module rr_queue_arbiter
  import arb_pkg::*;
#(
  parameter int NUM_QUEUES = 4,
  parameter int WIDTH      = 32,
  parameter int MAX_BURST  = 1
) (
  input  logic                           clk_i,
  input  logic                           rst_n_i,
  input  logic [NUM_QUEUES*WIDTH-1:0]    q_data_i,
  input  logic [NUM_QUEUES-1:0]          q_valid_i,
  output logic [NUM_QUEUES-1:0]          q_pop_o,
  output logic [WIDTH-1:0]               data_o,
  output logic [qid_width(NUM_QUEUES)-1:0] qid_o,
  output logic                           valid_o,
  input  logic                           ready_i
`ifdef ARB_GRANT_STATS_EN
  ,
  input  logic                           stat_clr_i,
  output logic [NUM_QUEUES*STAT_CNT_W-1:0] stat_grant_cnt_o
`endif
);

  localparam int QW = qid_width(NUM_QUEUES);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [QW-1:0] RST_OWNER = QW'(rst_owner(NUM_QUEUES));

  logic [QW-1:0] owner_q;
  logic [BW-1:0] burst_cnt_q;

  logic          load;
  logic          hold;
  logic [QW-1:0] start_idx;
  logic          pick_valid;
  logic [QW-1:0] pick_idx;
  logic          grant_valid;
  logic [QW-1:0] grant_idx;
  logic          pop;

  // The output register may take a new word when it is empty or when the
  // sink takes the current word.
  assign load = !valid_o || ready_i;

  // The owner keeps the grant while it still has data and its burst budget
  // is not used up. With MAX_BURST = 1 this is never true.
  assign hold = q_valid_i[owner_q] && (int'(burst_cnt_q) < MAX_BURST - 1);

  // The rotate search starts just past the owner, so the owner is checked
  // last.
  assign start_idx = (owner_q == QW'(NUM_QUEUES - 1)) ? '0 : owner_q + QW'(1);

  rr_priority_pick #(
    .N  (NUM_QUEUES),
    .IW (QW)
  ) u_pick (
    .req         (q_valid_i),
    .start_idx   (start_idx),
    .grant_valid (pick_valid),
    .grant_idx   (pick_idx)
  );

  assign grant_valid = hold || pick_valid;
  assign grant_idx   = hold ? owner_q : pick_idx;

  // Gating with rst_n_i stops the empty output register from popping
  // upstream queues while reset is held.
  assign pop = load && grant_valid && rst_n_i;

  always_comb begin
    q_pop_o = '0;
    if (pop) q_pop_o[grant_idx] = 1'b1;
  end

  // NOTE: state registers use non-blocking assignments only. Every flop
  // then samples values from before the edge, whatever order the blocks
  // run in.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_o     <= 1'b0;
      data_o      <= '0;
      qid_o       <= '0;
      owner_q     <= RST_OWNER;
      burst_cnt_q <= '0;
    end else if (load) begin
      if (grant_valid) begin
        data_o  <= q_data_i[int'(grant_idx)*WIDTH +: WIDTH];
        qid_o   <= grant_idx;
        valid_o <= 1'b1;
        if (hold) begin
          burst_cnt_q <= burst_cnt_q + BW'(1);
        end else begin
          // The owner changes on every non-hold grant. This also covers a
          // search that wraps round to the owner itself, which restarts
          // the owner's burst.
          owner_q     <= grant_idx;
          burst_cnt_q <= '0;
        end
      end else begin
        valid_o <= 1'b0;
      end
    end
  end

`ifdef ARB_GRANT_STATS_EN
  for (genvar k = 0; k < NUM_QUEUES; k++) begin : g_stat
    logic [STAT_CNT_W-1:0] cnt_q;

    // A clear takes priority over a pop in the same cycle. The counter
    // saturates at all-ones.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        cnt_q <= '0;
      end else if (stat_clr_i) begin
        cnt_q <= '0;
      end else if (q_pop_o[k] && (cnt_q != '1)) begin
        cnt_q <= cnt_q + STAT_CNT_W'(1);
      end
    end

    assign stat_grant_cnt_o[k*STAT_CNT_W +: STAT_CNT_W] = cnt_q;
  end
`endif

endmodule

// File: tb/tb_rr_queue_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rr_queue_arbiter
//   Directed bench for rr_queue_arbiter. It uses two instances that share
//   one clock and one reset:
//     dut_a : MAX_BURST = 1 (pure round robin)
//     dut_b : MAX_BURST = 3 (burst hold)
//   Inputs change on the falling edge. The bench samples pop strobes #1
//   later and registered outputs #1 after the rising edge.
//   With ARB_GRANT_STATS_EN defined, the grant counters are checked too.
// ---------------------------------------------------------------------------
module tb_rr_queue_arbiter;

  localparam int N = 4;
  localparam int W = 32;

  logic clk;
  logic rst_n;

  logic [N*W-1:0] a_data, b_data;
  logic [N-1:0]   a_valid, b_valid;
  logic [N-1:0]   a_pop, b_pop;
  logic [W-1:0]   a_dout, b_dout;
  logic [1:0]     a_qid, b_qid;
  logic           a_vout, b_vout;
  logic           a_ready, b_ready;
`ifdef ARB_GRANT_STATS_EN
  logic           a_clr, b_clr;
  logic [N*32-1:0] a_stat, b_stat;
`endif

  int checks = 0;
  int errors = 0;

  rr_queue_arbiter #(.NUM_QUEUES(N), .WIDTH(W), .MAX_BURST(1)) dut_a (
    .clk_i     (clk),
    .rst_n_i   (rst_n),
    .q_data_i  (a_data),
    .q_valid_i (a_valid),
    .q_pop_o   (a_pop),
    .data_o    (a_dout),
    .qid_o     (a_qid),
    .valid_o   (a_vout),
    .ready_i   (a_ready)
`ifdef ARB_GRANT_STATS_EN
    ,
    .stat_clr_i       (a_clr),
    .stat_grant_cnt_o (a_stat)
`endif
  );

  rr_queue_arbiter #(.NUM_QUEUES(N), .WIDTH(W), .MAX_BURST(3)) dut_b (
    .clk_i     (clk),
    .rst_n_i   (rst_n),
    .q_data_i  (b_data),
    .q_valid_i (b_valid),
    .q_pop_o   (b_pop),
    .data_o    (b_dout),
    .qid_o     (b_qid),
    .valid_o   (b_vout),
    .ready_i   (b_ready)
`ifdef ARB_GRANT_STATS_EN
    ,
    .stat_clr_i       (b_clr),
    .stat_grant_cnt_o (b_stat)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Call on a falling edge with inputs already set. The task checks the
  // pop strobe, crosses the rising edge, checks the registered outputs,
  // then returns on the next falling edge.
  task automatic step_a(input string tag, input logic [3:0] e_pop, input logic e_v,
                        input logic [1:0] e_qid, input logic [31:0] e_data);
    #1 check({tag, "_pop"}, 64'(a_pop), 64'(e_pop));
    @(posedge clk); #1;
    check({tag, "_valid"}, 64'(a_vout), 64'(e_v));
    check({tag, "_qid"},   64'(a_qid),  64'(e_qid));
    check({tag, "_data"},  64'(a_dout), 64'(e_data));
    @(negedge clk);
  endtask

  task automatic step_b(input string tag, input logic [3:0] e_pop, input logic e_v,
                        input logic [1:0] e_qid, input logic [31:0] e_data);
    #1 check({tag, "_pop"}, 64'(b_pop), 64'(e_pop));
    @(posedge clk); #1;
    check({tag, "_valid"}, 64'(b_vout), 64'(e_v));
    check({tag, "_qid"},   64'(b_qid),  64'(e_qid));
    check({tag, "_data"},  64'(b_dout), 64'(e_data));
    @(negedge clk);
  endtask

  initial begin
    rst_n   = 1'b0;
    a_data  = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    b_data  = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
    a_valid = 4'b1111;   // valid held high in reset must not pop
    b_valid = 4'b0000;
    a_ready = 1'b1;
    b_ready = 1'b1;
`ifdef ARB_GRANT_STATS_EN
    a_clr = 1'b0;
    b_clr = 1'b0;
`endif

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check("rst_a_pop",   64'(a_pop),  64'h0);
    check("rst_a_valid", 64'(a_vout), 64'h0);
    check("rst_a_data",  64'(a_dout), 64'h0);
    check("rst_a_qid",   64'(a_qid),  64'h0);
    check("rst_b_valid", 64'(b_vout), 64'h0);
`ifdef ARB_GRANT_STATS_EN
    check("rst_a_stat", 64'(a_stat[63:0]), 64'h0);
`endif

    // Pure round robin with all queues valid: pops 0,1,2,3,0.
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++)
      step_a("rr", 4'(1 << (i % 4)), 1'b1, 2'(i % 4), 32'hA0 + 32'(i % 4));

    // Backpressure: no pops and a stable word for 5 cycles.
    a_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      step_a("bp", 4'b0000, 1'b1, 2'd0, 32'hA0);
    // Ready returns: transfer and a new pop (owner 0, so queue 1) together.
    a_ready = 1'b1;
    step_a("bp_rel", 4'b0010, 1'b1, 2'd1, 32'hA1);

    // Only queue 2 valid: pop every cycle, valid stays high.
    a_valid = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      step_a("solo", 4'b0100, 1'b1, 2'd2, 32'hA2);
      check("solo_burst", 64'(dut_a.burst_cnt_q), 64'h0);
    end

    // All queues empty: valid drops and the data register holds.
    a_valid = 4'b0000;
    step_a("empty0", 4'b0000, 1'b0, 2'd2, 32'hA2);
    step_a("empty1", 4'b0000, 1'b0, 2'd2, 32'hA2);
    // Owner kept at 2, so the next search starts at queue 3.
    a_valid = 4'b1111;
    step_a("resume", 4'b1000, 1'b1, 2'd3, 32'hA3);

    // Asynchronous reset between edges, while the stream is still flowing.
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(a_vout), 64'h0);
    check("mid_rst_data",  64'(a_dout), 64'h0);
    check("mid_rst_qid",   64'(a_qid),  64'h0);
    check("mid_rst_pop",   64'(a_pop),  64'h0);
`ifdef ARB_GRANT_STATS_EN
    check("mid_rst_stat", 64'(a_stat[63:0]), 64'h0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    step_a("post_rst", 4'b0001, 1'b1, 2'd0, 32'hA0);
    a_valid = 4'b0000;

    // Burst hold of 3 with queues 1 and 2 valid: 1,1,1,2,2,2,1.
    b_valid = 4'b0110;
    step_b("burst0", 4'b0010, 1'b1, 2'd1, 32'hB1);
    step_b("burst1", 4'b0010, 1'b1, 2'd1, 32'hB1);
    step_b("burst2", 4'b0010, 1'b1, 2'd1, 32'hB1);
    step_b("burst3", 4'b0100, 1'b1, 2'd2, 32'hB2);
    step_b("burst4", 4'b0100, 1'b1, 2'd2, 32'hB2);
    step_b("burst5", 4'b0100, 1'b1, 2'd2, 32'hB2);
    step_b("burst6", 4'b0010, 1'b1, 2'd1, 32'hB1);
    b_valid = 4'b0000;

`ifdef ARB_GRANT_STATS_EN
    #1;
    check("stat_a_q0", 64'(a_stat[31:0]),   64'd1);
    check("stat_b_q1", 64'(b_stat[63:32]),  64'd4);
    check("stat_b_q2", 64'(b_stat[95:64]),  64'd3);
    // A clear wins over a pop in the same cycle.
    b_clr   = 1'b1;
    b_valid = 4'b0110;
    step_b("clr", 4'b0010, 1'b1, 2'd1, 32'hB1);
    check("clr_b_q1", 64'(b_stat[63:32]), 64'd0);
    check("clr_b_q2", 64'(b_stat[95:64]), 64'd0);
    b_clr   = 1'b0;
    b_valid = 4'b0000;
`endif

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
